// File: rtl/execute_muldiv_pkg.sv
// Shared types for the RV32M execute unit: funct3 op encoding, divider states, request/result records.
// Operand and tag widths are fixed here so every stage agrees on the record layout.
package execute_muldiv_pkg;
    localparam int XLEN   = 32;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE} div_state_e;

    typedef struct packed {
        muldiv_op_e        op;
        logic [XLEN-1:0]   src1;
        logic [XLEN-1:0]   src2;
        logic [PREG_W-1:0] dst_preg;
        logic [ROB_W-1:0]  rob_idx;
    } muldiv_req_t;

    typedef struct packed {
        logic [XLEN-1:0]   value;
        logic [PREG_W-1:0] dst_preg;
        logic [ROB_W-1:0]  rob_idx;
        logic              exception;
    } muldiv_res_t;

    // Operands are extended to 2*XLEN first so a plain unsigned multiply yields the exact low 2*XLEN product bits.
    function automatic logic [XLEN-1:0] mul_result(input muldiv_req_t req);
        logic              a_sgn;
        logic              b_sgn;
        logic [2*XLEN-1:0] a;
        logic [2*XLEN-1:0] b;
        logic [2*XLEN-1:0] p;
        a_sgn = (req.op == OP_MULH) || (req.op == OP_MULHSU);
        b_sgn = (req.op == OP_MULH);
        a = {{XLEN{a_sgn & req.src1[XLEN-1]}}, req.src1};
        b = {{XLEN{b_sgn & req.src2[XLEN-1]}}, req.src2};
        p = a * b;
        return (req.op == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction
endpackage

// File: rtl/execute_muldiv_divider.sv
// Iterative radix-2 restoring divider: XLEN+2 cycles to DONE (1 for div-by-zero/overflow).
// Holds its result in DONE until granted; one divide in flight, flush returns it to IDLE.
module muldiv_divider
    import execute_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  muldiv_req_t req,
    output logic        idle,
    output logic        done,
    input  logic        grant,
    output muldiv_res_t res
);
    localparam int CNT_W = $clog2(XLEN);

    div_state_e        state;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   dvsr;
    logic [XLEN-1:0]   val;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q;
    logic              neg_r;
    logic              want_rem;
    logic [PREG_W-1:0] dst;
    logic [ROB_W-1:0]  rob;

    logic              sgn;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              div_zero;
    logic              ovf;
    logic [XLEN:0]     trial;

    always_comb begin
        sgn      = (req.op == OP_DIV) || (req.op == OP_REM);
        mag1     = (sgn && req.src1[XLEN-1]) ? -req.src1 : req.src1;
        mag2     = (sgn && req.src2[XLEN-1]) ? -req.src2 : req.src2;
        div_zero = (req.src2 == '0);
        ovf      = sgn && (req.src1 == {1'b1, {(XLEN-1){1'b0}}}) && (req.src2 == '1);
        trial    = {rem, quo[XLEN-1]} - {1'b0, dvsr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DIV_IDLE;
            quo      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            val      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            want_rem <= 1'b0;
            dst      <= '0;
            rob      <= '0;
        end else if (flush) begin
            state <= DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    dst      <= req.dst_preg;
                    rob      <= req.rob_idx;
                    want_rem <= req.op[1];
                    neg_q    <= sgn && (req.src1[XLEN-1] ^ req.src2[XLEN-1]);
                    neg_r    <= sgn && req.src1[XLEN-1];
                    quo      <= mag1;
                    dvsr     <= mag2;
                    rem      <= '0;
                    cnt      <= '0;
                    if (div_zero) begin
                        val   <= req.op[1] ? req.src1 : '1;
                        state <= DIV_DONE;
                    end else if (ovf) begin
                        val   <= req.op[1] ? '0 : req.src1;
                        state <= DIV_DONE;
                    end else begin
                        state <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    if (!trial[XLEN]) begin
                        rem <= trial[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= {rem[XLEN-2:0], quo[XLEN-1]};
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(XLEN-1)) state <= DIV_FIX;
                end
                DIV_FIX: begin
                    val   <= want_rem ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
                    state <= DIV_DONE;
                end
                DIV_DONE: if (grant) state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign idle = (state == DIV_IDLE);
    assign done = (state == DIV_DONE);
    assign res  = '{value: val, dst_preg: dst, rob_idx: rob, exception: 1'b0};
endmodule

// File: rtl/execute_muldiv.sv
// RV32M execute unit: MUL_LAT-stage multiply pipe plus divider (EXEC_MULDIV_DIV_EN) sharing one registered output.
// Divider result beats the mul last stage; the mul pipe stalls as a unit when its last stage is not taken.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [XLEN-1:0]   in_src1,
    input  logic [XLEN-1:0]   in_src2,
    input  logic [PREG_W-1:0] in_dst_preg,
    input  logic [ROB_W-1:0]  in_rob_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_val,
    output logic [PREG_W-1:0] out_dst_preg,
    output logic [ROB_W-1:0]  out_rob_idx,
    output logic              out_exception
);
    muldiv_req_t        req;
    muldiv_res_t        mul_pipe [MUL_LAT];
    logic [MUL_LAT-1:0] mul_vld;
    muldiv_res_t        alt_res;
    muldiv_res_t        sel;
    logic               alt_vld;
    logic               div_free;
    logic               is_div;
    logic               out_load;
    logic               alt_grant;
    logic               mul_grant;
    logic               mul_adv;
    logic               accept;

    assign req = '{op: muldiv_op_e'(in_op), src1: in_src1, src2: in_src2,
                   dst_preg: in_dst_preg, rob_idx: in_rob_idx};
    assign is_div    = in_op[2];
    assign out_load  = !out_valid || out_ready;
    assign alt_grant = alt_vld && out_load;
    assign mul_grant = mul_vld[MUL_LAT-1] && out_load && !alt_vld;
    assign mul_adv   = !mul_vld[MUL_LAT-1] || mul_grant;
    assign in_ready  = is_div ? div_free : mul_adv;
    assign accept    = in_valid && in_ready && !flush;
    assign sel       = alt_vld ? alt_res : mul_pipe[MUL_LAT-1];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mul_vld <= '0;
        end else if (mul_adv) begin
            mul_vld[0] <= accept && !is_div;
            for (int i = 1; i < MUL_LAT; i++) mul_vld[i] <= mul_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (mul_adv) begin
            mul_pipe[0] <= '{value: mul_result(req), dst_preg: req.dst_preg,
                             rob_idx: req.rob_idx, exception: 1'b0};
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
        end
    end

`ifdef EXEC_MULDIV_DIV_EN
    logic div_idle;

    muldiv_divider u_divider (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .start (accept && is_div),
        .req   (req),
        .idle  (div_idle),
        .done  (alt_vld),
        .grant (alt_grant),
        .res   (alt_res)
    );

    assign div_free = div_idle;
`else
    // Without a divider, divide ops become a one-cycle illegal-op result held until granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            alt_vld <= 1'b0;
            alt_res <= '0;
        end else if (flush) begin
            alt_vld <= 1'b0;
        end else if (accept && is_div) begin
            alt_vld <= 1'b1;
            alt_res <= '{value: '0, dst_preg: req.dst_preg, rob_idx: req.rob_idx, exception: 1'b1};
        end else if (alt_grant) begin
            alt_vld <= 1'b0;
        end
    end

    assign div_free = !alt_vld || alt_grant;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_val       <= '0;
            out_dst_preg  <= '0;
            out_rob_idx   <= '0;
            out_exception <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_load) begin
            out_valid <= alt_vld || mul_vld[MUL_LAT-1];
            if (alt_vld || mul_vld[MUL_LAT-1]) begin
                out_val       <= sel.value;
                out_dst_preg  <= sel.dst_preg;
                out_rob_idx   <= sel.rob_idx;
                out_exception <= sel.exception;
            end
        end
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv: vector table for op results/latency plus hand sequences for
// back-to-back issue, backpressure, divide/multiply collision and flush.
module tb_execute_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_src1;
    logic [31:0] in_src2;
    logic [5:0]  in_dst_preg;
    logic [4:0]  in_rob_idx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_val;
    logic [5:0]  out_dst_preg;
    logic [4:0]  out_rob_idx;
    logic        out_exception;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] val;
        int          lat;
        logic        exc;
    } vec_t;

    always #5 clk = ~clk;

    execute_muldiv dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_src1       (in_src1),
        .in_src2       (in_src2),
        .in_dst_preg   (in_dst_preg),
        .in_rob_idx    (in_rob_idx),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_val       (out_val),
        .out_dst_preg  (out_dst_preg),
        .out_rob_idx   (out_rob_idx),
        .out_exception (out_exception)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rob);
        in_valid    = 1'b1;
        in_op       = op;
        in_src1     = a;
        in_src2     = b;
        in_rob_idx  = rob;
        in_dst_preg = {1'b0, rob};
    endtask

    // Issues one op with the output always ready and returns what first appears and after how many edges.
    task automatic run_one(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rob, output int lat, output logic [31:0] val,
                           output logic exc, output logic [4:0] orob, output logic [5:0] odst);
        drive(op, a, b, rob);
        check("issue_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 100);
        val  = out_val;
        exc  = out_exception;
        orob = out_rob_idx;
        odst = out_dst_preg;
        tick();
    endtask

    initial begin
        vec_t        vecs[$];
        int          lat;
        logic [31:0] val;
        logic        exc;
        logic [4:0]  orob;
        logic [5:0]  odst;
        logic        seen;

        vecs.push_back('{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 3, 1'b0});
        vecs.push_back('{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 1'b0});
        vecs.push_back('{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 3, 1'b0});
        vecs.push_back('{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 3, 1'b0});
        vecs.push_back('{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 3, 1'b0});
        vecs.push_back('{3'd0, 32'h00012345, 32'h00010000, 32'h23450000, 3, 1'b0});
`ifdef EXEC_MULDIV_DIV_EN
        vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0});
        vecs.push_back('{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0});
        vecs.push_back('{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0});
        vecs.push_back('{3'd7, 32'd5,        32'd0,        32'd5,        1,  1'b0});
        vecs.push_back('{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0});
        vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b0});
        vecs.push_back('{3'd5, 32'd100,      32'd7,        32'd14,       34, 1'b0});
        vecs.push_back('{3'd7, 32'd100,      32'd7,        32'd2,        34, 1'b0});
`else
        vecs.push_back('{3'd4, 32'hFFFFFFF9, 32'd2,        32'd0,        1,  1'b1});
        vecs.push_back('{3'd5, 32'd5,        32'd0,        32'd0,        1,  1'b1});
        vecs.push_back('{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b1});
        vecs.push_back('{3'd7, 32'd100,      32'd7,        32'd0,        1,  1'b1});
`endif

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = 3'd0; in_src1 = '0; in_src2 = '0; in_dst_preg = '0; in_rob_idx = '0;
        repeat (3) tick();
        rst = 1'b0;

        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_val", out_val, 32'd0);
        check("rst_out_dst", 32'(out_dst_preg), 32'd0);
        check("rst_out_rob", 32'(out_rob_idx), 32'd0);
        check("rst_out_exc", 32'(out_exception), 32'd0);
        check("rst_in_ready_mul", 32'(in_ready), 32'd1);
        in_op = 3'd4;
        check("rst_in_ready_div", 32'(in_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            run_one(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), lat, val, exc, orob, odst);
            check($sformatf("vec%0d_val", i), val, vecs[i].val);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_exc", i), 32'(exc), 32'(vecs[i].exc));
            check($sformatf("vec%0d_rob", i), 32'(orob), 32'(i + 1));
            check($sformatf("vec%0d_dst", i), 32'(odst), 32'(i + 1));
        end

        // Back-to-back multiplies: one result per cycle once the pipe fills.
        for (int i = 0; i < 4; i++) begin
            drive(3'd0, 32'(i + 2), 32'd5, 5'(8 + i));
            check("b2b_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("b2b_rob%0d", i), 32'(out_rob_idx), 32'(8 + i));
            check($sformatf("b2b_val%0d", i), out_val, 32'((i + 2) * 5));
            tick();
        end

        // Backpressure: output held off for 5 edges while 4 multiplies are issued.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(3'd0, 32'(i + 1), 32'd3, 5'(16 + i));
            check("bp_issue_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        in_op = 3'd0;
        check("bp_stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp_rob%0d", i), 32'(out_rob_idx), 32'(16 + i));
            check($sformatf("bp_val%0d", i), out_val, 32'(3 * (i + 1)));
            tick();
        end
        check("bp_drained", 32'(out_valid), 32'd0);

`ifdef EXEC_MULDIV_DIV_EN
        // Divide and multiply reach the output arbiter together; the divide goes first.
        drive(3'd5, 32'd100, 32'd7, 5'd20);
        tick();
        in_valid = 1'b0;
        tick();
        in_op = 3'd4;
        check("div_busy_in_ready", 32'(in_ready), 32'd0);
        in_op = 3'd0;
        check("div_busy_mul_ready", 32'(in_ready), 32'd1);
        repeat (29) tick();
        drive(3'd0, 32'd6, 32'd7, 5'd21);
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        check("coll_pre_valid", 32'(out_valid), 32'd0);
        tick();
        check("coll_first_rob", 32'(out_rob_idx), 32'd20);
        check("coll_first_val", out_val, 32'd14);
        tick();
        check("coll_second_valid", 32'(out_valid), 32'd1);
        check("coll_second_rob", 32'(out_rob_idx), 32'd21);
        check("coll_second_val", out_val, 32'd42);
        tick();
`else
        // Illegal divide result and multiply reach the output arbiter together; the divide goes first.
        drive(3'd0, 32'd6, 32'd7, 5'd21);
        tick();
        in_valid = 1'b0;
        tick();
        drive(3'd4, 32'd100, 32'd7, 5'd20);
        tick();
        in_valid = 1'b0;
        in_op = 3'd4;
        check("div_free_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("coll_first_rob", 32'(out_rob_idx), 32'd20);
        check("coll_first_exc", 32'(out_exception), 32'd1);
        check("coll_first_val", out_val, 32'd0);
        tick();
        check("coll_second_valid", 32'(out_valid), 32'd1);
        check("coll_second_rob", 32'(out_rob_idx), 32'd21);
        check("coll_second_exc", 32'(out_exception), 32'd0);
        check("coll_second_val", out_val, 32'd42);
        tick();
`endif

        // Flush 10 edges into a divide with two multiplies in flight; a MUL offered during flush is ignored.
        drive(3'd4, 32'd100, 32'd7, 5'd22);
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        drive(3'd0, 32'd3, 32'd3, 5'd23);
        tick();
        drive(3'd0, 32'd4, 32'd4, 5'd24);
        tick();
        drive(3'd0, 32'd5, 32'd5, 5'd25);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        in_op = 3'd4;
        check("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("flush_no_out", 32'(seen), 32'd0);
        run_one(3'd4, 32'd100, 32'd7, 5'd26, lat, val, exc, orob, odst);
        check("post_flush_rob", 32'(orob), 32'd26);
`ifdef EXEC_MULDIV_DIV_EN
        check("post_flush_val", val, 32'd14);
        check("post_flush_latency", 32'(lat), 32'd34);
`else
        check("post_flush_exc", 32'(exc), 32'd1);
        check("post_flush_latency", 32'(lat), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
